// File: rtl/stream_cipher_pkg.sv
// Shared definitions for the stream-cipher receive path.
//   WORD_W          default data / keystream / password width
//   FIFO_DEPTH_DEF  default ciphertext buffer depth (power of 2, >= 2)
//   CNT_W_DEF       default width of the delivered-word counter
//   state_t         session FSM states
package stream_cipher_pkg;
    localparam int WORD_W         = 24;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_INIT, RUN} state_t;
endpackage

// File: rtl/cipher_fifo.sv
// Ciphertext buffer: synchronous FIFO, async active-low reset.
//   clk, rst          clock, reset (0 = reset)
//   wr_en, wr_data    push a word
//   rd_en             pop the head word
//   flush             drop all contents (wins over push/pop)
//   head              word at the read pointer
//   full, empty       from the registered occupancy count
module cipher_fifo
    import stream_cipher_pkg::*;
#(
    parameter int n          = WORD_W,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [n-1:0] wr_data,
    input  logic         rd_en,
    input  logic         flush,
    output logic [n-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [n-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_wr, do_rd;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    // Guard against overflow/underflow even if a caller misbehaves.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage needs no reset; occupancy is governed by the count alone.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

    // Pointers are log2(depth) wide, so they wrap modulo the depth naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/stream_decrypt.sv
// RC4 link receive side: plaintext = ciphertext XOR keystream, one keystream
// word per ciphertext word, in order, never skipping a keystream word.
//   clk, rst                        clock, async active-low reset
//   password, key_load              new session key / start pulse
//   ks_start, ks_key                key-schedule kick and key to generator
//   ks_init_done                    generator ready (level)
//   ks_valid, ks_data, ks_ready     keystream handshake (ks_ready = consumed)
//   ct_valid, ct_data, ct_ready     ciphertext in
//   pt_valid, pt_data, pt_ready     plaintext out (registered)
//   word_count                      plaintext words delivered, saturating
//   busy                            any state other than IDLE
module stream_decrypt
    import stream_cipher_pkg::*;
#(
    parameter int n          = WORD_W,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n-1:0]     password,
    input  logic             key_load,
    output logic             ks_start,
    output logic [n-1:0]     ks_key,
    input  logic             ks_init_done,
    input  logic             ks_valid,
    input  logic [n-1:0]     ks_data,
    output logic             ks_ready,
    input  logic             ct_valid,
    input  logic [n-1:0]     ct_data,
    output logic             ct_ready,
    output logic             pt_valid,
    output logic [n-1:0]     pt_data,
    input  logic             pt_ready,
    output logic [CNT_W-1:0] word_count,
    output logic             busy
);
    state_t       state, state_nxt;
    logic         run, fire;
    logic         fifo_full, fifo_empty;
    logic [n-1:0] fifo_head;

    assign run      = (state == RUN);
    assign busy     = (state != IDLE);
    assign ks_start = (state == LOAD);
    assign ct_ready = run & ~fifo_full & ~key_load;
    // key_load aborts the session, so no keystream may be taken in that cycle.
    assign fire     = run & ~fifo_empty & ks_valid & (~pt_valid | pt_ready) & ~key_load;
    assign ks_ready = fire;

    cipher_fifo #(.n(n), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ct_valid & ct_ready),
        .wr_data (ct_data),
        .rd_en   (fire),
        .flush   (key_load),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (key_load) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:      state_nxt = IDLE;
                LOAD:      state_nxt = WAIT_INIT;
                WAIT_INIT: if (ks_init_done) state_nxt = RUN;
                RUN:       state_nxt = RUN;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ks_key     <= '0;
            pt_valid   <= 1'b0;
            pt_data    <= '0;
            word_count <= '0;
        end else if (key_load) begin
            ks_key     <= password;
            pt_valid   <= 1'b0;
            word_count <= '0;
        end else begin
            if (fire) begin
                pt_data  <= fifo_head ^ ks_data;
                pt_valid <= 1'b1;
            end else if (pt_valid && pt_ready) begin
                pt_valid <= 1'b0;
            end
            if (pt_valid && pt_ready && word_count != '1)
                word_count <= word_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_decrypt.sv
// Bench for stream_decrypt: directed stimulus, an external keystream source
// driven from a fixed table, and a queue-based model that pairs the k-th
// accepted ciphertext word with the k-th keystream word of the session.
module tb_stream_decrypt;
    localparam int N = 24;

    logic          clk = 1'b0, rst = 1'b0;
    logic [N-1:0]  password = '0;
    logic          key_load = 1'b0;
    logic          ks_start;
    logic [N-1:0]  ks_key;
    logic          ks_init_done = 1'b0, ks_valid = 1'b0;
    logic [N-1:0]  ks_data;
    logic          ks_ready;
    logic          ct_valid = 1'b0;
    logic [N-1:0]  ct_data = '0;
    logic          ct_ready, pt_valid;
    logic [N-1:0]  pt_data;
    logic          pt_ready = 1'b0;
    logic [15:0]   word_count;
    logic          busy;

    stream_decrypt dut (
        .clk(clk), .rst(rst), .password(password), .key_load(key_load),
        .ks_start(ks_start), .ks_key(ks_key), .ks_init_done(ks_init_done),
        .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready),
        .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready),
        .word_count(word_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Keystream source: the k-th word taken in a session is ks_list[k].
    logic [N-1:0] ks_list [64];
    logic [5:0]   ks_ptr;
    assign ks_data = ks_list[ks_ptr];
    always @(posedge clk or negedge rst) begin
        if (!rst)                       ks_ptr <= '0;
        else if (key_load)              ks_ptr <= '0;
        else if (ks_valid && ks_ready)  ks_ptr <= ks_ptr + 1'b1;
    end

    // Model: accepted ciphertext queue, delivered / consumed counts.
    logic [N-1:0] acc_q [$];
    int           dlv = 0, cons = 0;
    bit           hold_p = 0;
    logic [N-1:0] hold_v = '0;

    always @(negedge clk) begin
        if (!rst) begin
            acc_q.delete(); dlv = 0; cons = 0; hold_p = 0;
        end else begin
            chk("word_count", word_count, dlv);
            if (hold_p) begin
                chk("hold_valid", pt_valid, 1);
                chk("hold_data", pt_data, hold_v);
            end
            if (key_load) begin
                chk("ks_ready_on_load", ks_ready, 0);
                acc_q.delete(); dlv = 0; cons = 0; hold_p = 0;
            end else begin
                if (ks_ready) begin
                    chk("ks_align", 32'(ks_valid && cons < acc_q.size()), 1);
                    cons++;
                end
                if (pt_valid && pt_ready) begin
                    if (dlv < acc_q.size()) chk("pt_data", pt_data, acc_q[dlv] ^ ks_list[dlv]);
                    else                    chk("pt_extra", dlv, acc_q.size());
                    dlv++;
                end
                if (ct_valid && ct_ready) acc_q.push_back(ct_data);
                hold_p = pt_valid && !pt_ready;
                hold_v = pt_data;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ks_start"}, ks_start, 0);
        chk({tag, "_ks_key"}, ks_key, 0);
        chk({tag, "_ks_ready"}, ks_ready, 0);
        chk({tag, "_ct_ready"}, ct_ready, 0);
        chk({tag, "_pt_valid"}, pt_valid, 0);
        chk({tag, "_pt_data"}, pt_data, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Key load, then ks_init_done five cycles after the key_load cycle.
    task automatic start_session(input logic [N-1:0] pw);
        password = pw; key_load = 1'b1; ks_init_done = 1'b0;
        @(negedge clk);
        chk("ct_ready_on_load", ct_ready, 0);
        step();
        key_load = 1'b0; ct_valid = 1'b0;
        chk("load_ks_start", ks_start, 1);
        chk("load_ks_key", ks_key, pw);
        chk("load_busy", busy, 1);
        chk("load_pt_valid", pt_valid, 0);
        chk("load_word_count", word_count, 0);
        step();
        chk("wait_ks_start", ks_start, 0);
        step(); step(); step();
        ks_init_done = 1'b1;
        @(negedge clk);
        chk("wait_ct_ready", ct_ready, 0);
        step();
        chk("run_ct_ready", ct_ready, 1);
        chk("run_busy", busy, 1);
    endtask

    task automatic drain(input int target);
        int t;
        for (t = 0; t < 30; t++) begin
            if (word_count == 16'(target) && !pt_valid) break;
            step();
        end
        chk("drain_timeout", word_count, target);
    endtask

    logic [N-1:0] sw [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    logic [N-1:0] bw [3] = '{24'hA1B2C3, 24'h0000FF, 24'h800000};
    int           acc, hi, base;
    logic [N-1:0] hv;

    initial begin
        for (int i = 0; i < 64; i++) ks_list[i] = 24'(i * 24'h13579B) ^ 24'h5A5A5A;
        ks_list[0] = 24'h0F0F0F;
        ks_list[1] = 24'hFFFFFF;

        // Reset state
        #12;
        chk_all_zero("reset");
        step(); rst = 1'b1;
        step(); step();
        chk("idle_busy", busy, 0);

        // Session start
        start_session(24'h123456);

        // Basic decrypt
        ks_valid = 1'b1; pt_ready = 1'b1;
        ct_valid = 1'b1; ct_data = 24'h1F2E3D;
        step();
        ct_data = 24'h000001;
        step();
        chk("basic_pt0_valid", pt_valid, 1);
        chk("basic_pt0", pt_data, 24'h102132);
        ct_valid = 1'b0;
        step();
        chk("basic_pt1", pt_data, 24'hFFFFFE);
        step();
        chk("basic_count", word_count, 2);
        chk("basic_idle_out", pt_valid, 0);

        // Keystream stall: 4 fit, the 5th waits
        ks_valid = 1'b0; acc = 0; hi = 0;
        for (int i = 0; i < 6; i++) begin
            ct_valid = 1'b1; ct_data = sw[acc];
            @(negedge clk);
            if (ks_ready) hi++;
            if (ct_ready) acc++;
            step();
        end
        chk("stall_accepted", acc, 4);
        chk("stall_ks_ready", hi, 0);
        ks_valid = 1'b1; ct_data = sw[4];
        @(negedge clk);
        chk("full_no_reopen", ct_ready, 0);
        chk("stall_release_pop", ks_ready, 1);
        step();
        for (int t = 0; t < 10 && acc < 5; t++) begin
            @(negedge clk);
            if (ct_ready) acc++;
            step();
        end
        chk("stall_fifth", acc, 5);
        ct_valid = 1'b0;
        drain(7);

        // Backpressure
        pt_ready = 1'b0; base = int'(ks_ptr);
        for (int i = 0; i < 3; i++) begin
            ct_valid = 1'b1; ct_data = bw[i]; step();
        end
        ct_valid = 1'b0;
        hv = pt_data;
        chk("bp_valid", pt_valid, 1);
        chk("bp_first", hv, bw[0] ^ ks_list[base]);
        step(); step(); step();
        chk("bp_stable", pt_data, hv);
        chk("bp_ks_once", int'(ks_ptr) - base, 1);
        pt_ready = 1'b1;
        drain(10);
        chk("bp_ks_total", int'(ks_ptr) - base, 3);

        // Re-key mid-stream: output held, two words buffered
        pt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ct_valid = 1'b1; ct_data = sw[i]; step();
        end
        chk("rekey_pre_valid", pt_valid, 1);
        ct_data = 24'h777777;
        start_session(24'hABCDEF);
        pt_ready = 1'b1;
        step(); step(); step();
        chk("rekey_flushed", pt_valid, 0);
        chk("rekey_count", word_count, 0);
        ct_valid = 1'b1; ct_data = 24'h333333;
        step();
        ct_valid = 1'b0;
        step();
        chk("rekey_first_pt", pt_data, 24'h3C3C3C);
        drain(1);

        // Async reset mid-RUN
        pt_ready = 1'b0;
        ct_valid = 1'b1; ct_data = 24'h13579B; step();
        ct_data = 24'h2468AC; step();
        ct_valid = 1'b0;
        #3 rst = 1'b0;
        #1 chk_all_zero("async");
        #2 rst = 1'b1;
        ct_valid = 1'b1; ks_valid = 1'b1; ks_init_done = 1'b1; pt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_reset_busy", busy, 0);
            chk("post_reset_ct_ready", ct_ready, 0);
            chk("post_reset_ks_start", ks_start, 0);
        end
        start_session(24'h123456);
        ct_valid = 1'b1; ct_data = 24'h0F0F0F; step();
        ct_valid = 1'b0;
        step();
        chk("restart_pt", pt_data, 24'h000000);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
